// File: rtl/sec_an_decoder_iter.sv
// Iterative single-error-correcting AN-code decoder: residue search for +/-2^i, then restoring division by A.
// Latency W_BITS+2 (clean / uncorrectable) or W_BITS+i+3 (error at bit i); w_ready only in IDLE, result held until n_ready.
module sec_an_decoder_iter #(
   parameter int W_BITS = 38,
   parameter int N_BITS = 31,
   parameter int A      = 83
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [W_BITS-1:0]           W,
   input  logic                        w_valid,
   output logic                        w_ready,
   output logic [N_BITS-1:0]           N,
   output logic                        found,
   input  logic                        n_ready,
   output logic                        err_flag,
   output logic [$clog2(W_BITS)-1:0]   err_pos,
   output logic                        err_sign,
   output logic                        uncorr
);

   localparam int PW = $clog2(W_BITS);
   localparam int CW = $clog2(W_BITS + 1);
   localparam int RW = $clog2(A) + 1;
   localparam logic [W_BITS-1:0] A_W = W_BITS'(A);
   localparam logic [RW-1:0]     A_R = RW'(A);

   typedef enum logic [2:0] {IDLE, CHECK, SEARCH, DIV, DONE} state_t;

   state_t            state, state_nx;
   logic [W_BITS-1:0] cw;
   logic [RW-1:0]     rem;
   logic [RW-1:0]     p;
   logic [CW-1:0]     cnt;
   logic              pend_flag;
   logic [PW-1:0]     pend_pos;
   logic              pend_sign;

   logic [RW-1:0]     r_mod;
   logic [W_BITS:0]   pow;
   logic [W_BITS:0]   add_sum;
   logic              sub_ok, add_ok, cnt_end;
   logic              m_plus, m_minus;
   logic [RW-1:0]     p_dbl, p_next;
   logic [RW-1:0]     rem_sh, rem_nx;
   logic              q_bit;

   assign r_mod   = RW'(cw % A_W);
   assign pow     = {{W_BITS{1'b0}}, 1'b1} << cnt;
   assign add_sum = {1'b0, cw} + pow;
   assign sub_ok  = {1'b0, cw} >= pow;
   assign add_ok  = !add_sum[W_BITS];
   assign cnt_end = (cnt == CW'(W_BITS));

   // rem holds the codeword residue during SEARCH; p walks through 2^i mod A.
   assign m_plus  = !cnt_end && (rem == p) && sub_ok;
   assign m_minus = !cnt_end && (rem == A_R - p) && add_ok;
   assign p_dbl   = RW'({p, 1'b0});
   assign p_next  = (p_dbl >= A_R) ? p_dbl - A_R : p_dbl;

   // Restoring division: the codeword shifts out MSB-first while quotient bits shift in.
   assign rem_sh  = RW'({rem, cw[W_BITS-1]});
   assign q_bit   = rem_sh >= A_R;
   assign rem_nx  = q_bit ? rem_sh - A_R : rem_sh;

   assign w_ready = (state == IDLE);
   assign found   = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (w_valid) state_nx = CHECK;
         CHECK:   state_nx = (r_mod == '0) ? DIV : SEARCH;
         SEARCH: begin
            if (m_plus || m_minus) state_nx = DIV;
            else if (cnt_end)      state_nx = DONE;
         end
         DIV:     if (cnt_end) state_nx = DONE;
         DONE:    if (n_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cw        <= '0;
         rem       <= '0;
         p         <= '0;
         cnt       <= '0;
         pend_flag <= 1'b0;
         pend_pos  <= '0;
         pend_sign <= 1'b0;
         N         <= '0;
         err_flag  <= 1'b0;
         err_pos   <= '0;
         err_sign  <= 1'b0;
         uncorr    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (w_valid) begin
               cw        <= W;
               rem       <= '0;
               p         <= '0;
               cnt       <= '0;
               pend_flag <= 1'b0;
               pend_pos  <= '0;
               pend_sign <= 1'b0;
               err_flag  <= 1'b0;
               err_pos   <= '0;
               err_sign  <= 1'b0;
               uncorr    <= 1'b0;
            end
            CHECK: begin
               cnt <= '0;
               if (r_mod == '0) begin
                  rem <= '0;
               end else begin
                  rem <= r_mod;
                  p   <= RW'(1);
               end
            end
            SEARCH: begin
               if (m_plus) begin
                  cw        <= cw - pow[W_BITS-1:0];
                  pend_flag <= 1'b1;
                  pend_pos  <= PW'(cnt);
                  pend_sign <= 1'b1;
                  rem       <= '0;
                  cnt       <= '0;
               end else if (m_minus) begin
                  cw        <= add_sum[W_BITS-1:0];
                  pend_flag <= 1'b1;
                  pend_pos  <= PW'(cnt);
                  pend_sign <= 1'b0;
                  rem       <= '0;
                  cnt       <= '0;
               end else if (cnt_end) begin
                  N      <= '0;
                  uncorr <= 1'b1;
               end else begin
                  p   <= p_next;
                  cnt <= cnt + 1'b1;
               end
            end
            DIV: begin
               if (cnt_end) begin
                  N        <= cw[N_BITS-1:0];
                  uncorr   <= |cw[W_BITS-1:N_BITS];
                  err_flag <= pend_flag;
                  err_pos  <= pend_pos;
                  err_sign <= pend_sign;
               end else begin
                  cw  <= {cw[W_BITS-2:0], q_bit};
                  rem <= rem_nx;
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
